// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one memory op at a time, IDLE -> REQ -> WAIT -> DONE.
// Define LSU_MISALIGN_EXC_EN to trap misaligned half/word accesses through out_ale.
module lsu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [2:0]  in_mode,
    input  logic        in_us,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        data_sram_req,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    output logic [1:0]  data_sram_cs,
    output logic [2:0]  data_sram_mode,
    output logic        data_sram_us,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_ale,
    output logic [1:0]  dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits for ready, and the sender holds its payload until the transfer.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic [2:0]  size_q;
    logic        us_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic [2:0]  size_dec;
    logic        is_mem;
    logic        misaligned;

    assign accept = in_valid && (state == IDLE);
    assign is_mem = (in_op == 2'b01) || (in_op == 2'b10);

    // One-hot size {word, half, byte}; byte wins over half over word, 000 means word.
    always_comb begin
        size_dec = 3'b000;
        if (in_mode[0])
            size_dec = 3'b001;
        else if (in_mode[1])
            size_dec = 3'b010;
        else if (in_mode[2] || (in_mode == 3'b000))
            size_dec = 3'b100;
    end

`ifdef LSU_MISALIGN_EXC_EN
    logic ale_q;
    assign misaligned = is_mem && ((size_dec[1] && in_addr[0]) ||
                                   (size_dec[2] && (in_addr[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= 2'b00;
            size_q  <= 3'b000;
            us_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            op_q    <= in_op;
            size_q  <= size_dec;
            us_q    <= in_us;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
        end
    end

`ifdef LSU_MISALIGN_EXC_EN
    always_ff @(posedge clk) begin
        if (reset)
            ale_q <= 1'b0;
        else if (accept)
            ale_q <= misaligned;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (is_mem && !misaligned) ? REQ : DONE;
            REQ:  if (data_sram_addr_ok) state_nxt = WAIT;
            WAIT: if (data_sram_data_ok) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic busy;
    assign busy = (state != IDLE);

    always_comb begin
        in_ready        = (state == IDLE);
        data_sram_req   = (state == REQ);
        out_valid       = (state == DONE);
        dbg_state       = state;
        data_sram_addr  = {addr_q[31:2], 2'b00};
        data_sram_cs    = busy ? addr_q[1:0] : 2'b00;
        data_sram_mode  = busy ? size_q : 3'b000;
        data_sram_us    = busy ? us_q : 1'b0;
        data_sram_wstrb = 4'b0000;
        if (busy && (op_q == 2'b10)) begin
            if (size_q[0])
                data_sram_wstrb = 4'b0001 << addr_q[1:0];
            else if (size_q[1])
                data_sram_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            else
                data_sram_wstrb = 4'b1111;
        end
        if (size_q[0])
            data_sram_wdata = {4{wdata_q[7:0]}};
        else if (size_q[1])
            data_sram_wdata = {2{wdata_q[15:0]}};
        else
            data_sram_wdata = wdata_q;
`ifdef LSU_MISALIGN_EXC_EN
        out_ale = (state == DONE) && ale_q;
`else
        out_ale = 1'b0;
`endif
    end

endmodule
